// File: rtl/dstack_file.sv
// Data-stack storage built as a shift-register array with entry 0 as top of stack.
// Executes replace/push/pop1/pop2/rotate commands and keeps sticky overflow/underflow flags.
module dstack_file #(
   parameter int WORD_WIDTH = 32,
   parameter int DEPTH      = 64,
   parameter int DEPTH_BITS = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  halt,
   input  logic [1:0]            movement,
   input  logic [WORD_WIDTH-1:0] next_top,
   input  logic                  rotate,
   input  logic [5:0]            rotate_addr,
   input  logic                  clear_flags,
   output logic [WORD_WIDTH-1:0] top,
   output logic [WORD_WIDTH-1:0] second,
   output logic [WORD_WIDTH-1:0] third,
   output logic [WORD_WIDTH-1:0] rotate_value,
   output logic [DEPTH_BITS-1:0] depth,
   output logic                  overflow,
   output logic                  underflow
);

   typedef enum logic [1:0] {
      MOVE_REPLACE = 2'b00,
      MOVE_PUSH    = 2'b01,
      MOVE_POP1    = 2'b10,
      MOVE_POP2    = 2'b11
   } movement_t;

   localparam logic [DEPTH_BITS-1:0] DEPTH_MAX = DEPTH_BITS'(DEPTH);
   localparam logic [DEPTH_BITS-1:0] ONE       = DEPTH_BITS'(1);
   localparam logic [DEPTH_BITS-1:0] TWO       = DEPTH_BITS'(2);

   logic [WORD_WIDTH-1:0] entries      [DEPTH];
   logic [WORD_WIDTH-1:0] entries_next [DEPTH];
   logic [DEPTH_BITS-1:0] depth_next;
   logic                  set_overflow;
   logic                  set_underflow;
   logic                  rotate_in_range;
   movement_t             move_cmd;

   assign top      = entries[0];
   assign second   = entries[1];
   assign third    = entries[2];
   assign move_cmd = movement_t'(movement);

   assign rotate_in_range = int'(rotate_addr) < DEPTH;

   always_comb begin
      rotate_value = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (int'(rotate_addr) == i) rotate_value = entries[i];
      end
   end

   // Next array contents and occupancy; entry 0 always takes next_top because
   // the controller has already chosen the surviving top value.
   always_comb begin
      entries_next  = entries;
      depth_next    = depth;
      set_overflow  = 1'b0;
      set_underflow = 1'b0;
      entries_next[0] = next_top;
      if (rotate) begin
         if (rotate_in_range) begin
            for (int i = 1; i < DEPTH; i++) begin
               if (i <= int'(rotate_addr)) entries_next[i] = entries[i-1];
            end
            set_underflow = int'(rotate_addr) >= int'(depth);
         end else begin
            set_underflow = 1'b1;
         end
      end else begin
         case (move_cmd)
            MOVE_PUSH: begin
               for (int i = 1; i < DEPTH; i++) entries_next[i] = entries[i-1];
               set_overflow = depth == DEPTH_MAX;
               depth_next   = (depth == DEPTH_MAX) ? DEPTH_MAX : depth + ONE;
            end
            MOVE_POP1: begin
               for (int i = 1; i < DEPTH - 1; i++) entries_next[i] = entries[i+1];
               entries_next[DEPTH-1] = '0;
               set_underflow = depth < ONE;
               depth_next    = (depth < ONE) ? '0 : depth - ONE;
            end
            MOVE_POP2: begin
               for (int i = 1; i < DEPTH - 2; i++) entries_next[i] = entries[i+2];
               entries_next[DEPTH-2] = '0;
               entries_next[DEPTH-1] = '0;
               set_underflow = depth < TWO;
               depth_next    = (depth < TWO) ? '0 : depth - TWO;
            end
            default: ;
         endcase
      end
   end

   // While halted only clear_flags may act; a set in the same cycle beats a clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
         depth     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (halt) begin
         if (clear_flags) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
         end
      end else begin
         entries   <= entries_next;
         depth     <= depth_next;
         overflow  <= set_overflow  | (overflow  & ~clear_flags);
         underflow <= set_underflow | (underflow & ~clear_flags);
      end
   end

endmodule

// File: tb/tb_dstack_file.sv
// Directed self-checking bench for dstack_file using a small DEPTH so that
// saturation, bottom-discard and out-of-range rotate cases are reachable.
module tb_dstack_file;

   localparam int WW     = 32;
   localparam int DEPTH  = 8;
   localparam int DBITS  = $clog2(DEPTH + 1);

   logic             clk;
   logic             reset_n;
   logic             halt;
   logic [1:0]       movement;
   logic [WW-1:0]    next_top;
   logic             rotate;
   logic [5:0]       rotate_addr;
   logic             clear_flags;
   logic [WW-1:0]    top;
   logic [WW-1:0]    second;
   logic [WW-1:0]    third;
   logic [WW-1:0]    rotate_value;
   logic [DBITS-1:0] depth;
   logic             overflow;
   logic             underflow;

   int check_count;
   int error_count;

   dstack_file #(.WORD_WIDTH(WW), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .halt         (halt),
      .movement     (movement),
      .next_top     (next_top),
      .rotate       (rotate),
      .rotate_addr  (rotate_addr),
      .clear_flags  (clear_flags),
      .top          (top),
      .second       (second),
      .third        (third),
      .rotate_value (rotate_value),
      .depth        (depth),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Presents one command, lets one rising edge take it, then settles 1ns past the edge.
   task automatic applyStimulus(input logic h, input logic [1:0] mv, input logic [WW-1:0] nt,
                                input logic rot, input logic [5:0] ra, input logic clr);
      halt        = h;
      movement    = mv;
      next_top    = nt;
      rotate      = rot;
      rotate_addr = ra;
      clear_flags = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [WW-1:0] nt);
      applyStimulus(1'b0, 2'b01, nt, 1'b0, 6'd0, 1'b0);
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
   endtask

   initial begin
      check_count = 0;
      error_count = 0;
      reset_n     = 1'b0;
      halt        = 1'b0;
      movement    = 2'b00;
      next_top    = '0;
      rotate      = 1'b0;
      rotate_addr = '0;
      clear_flags = 1'b0;
      #1;
      checkOutput("reset_top", top, 32'h0);
      checkOutput("reset_depth", 32'(depth), 32'd0);
      checkOutput("reset_flags", {30'd0, overflow, underflow}, 32'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Basic push / pop behaviour
      push(32'h11);
      push(32'h22);
      push(32'h33);
      checkOutput("push_top", top, 32'h33);
      checkOutput("push_second", second, 32'h22);
      checkOutput("push_third", third, 32'h11);
      checkOutput("push_depth", 32'(depth), 32'd3);
      checkOutput("push_flags", {30'd0, overflow, underflow}, 32'd0);

      applyStimulus(1'b0, 2'b10, 32'h22, 1'b0, 6'd0, 1'b0);
      checkOutput("pop1_top", top, 32'h22);
      checkOutput("pop1_second", second, 32'h11);
      checkOutput("pop1_third", third, 32'h0);
      checkOutput("pop1_depth", 32'(depth), 32'd2);
      applyStimulus(1'b0, 2'b11, 32'h5, 1'b0, 6'd0, 1'b0);
      checkOutput("pop2_top", top, 32'h5);
      checkOutput("pop2_second", second, 32'h0);
      checkOutput("pop2_depth", 32'(depth), 32'd0);
      checkOutput("pop2_underflow", 32'(underflow), 32'd0);
      applyStimulus(1'b0, 2'b10, 32'h6, 1'b0, 6'd0, 1'b0);
      checkOutput("pop_empty_depth", 32'(depth), 32'd0);
      checkOutput("pop_empty_underflow", 32'(underflow), 32'd1);
      applyStimulus(1'b0, 2'b00, 32'h7, 1'b0, 6'd0, 1'b0);
      checkOutput("underflow_sticky", 32'(underflow), 32'd1);

      // Rotate
      pulse_reset();
      push(32'hA);
      push(32'hB);
      push(32'hC);
      push(32'hD);
      rotate_addr = 6'd3;
      #1;
      checkOutput("rotval_pre", rotate_value, 32'hA);
      applyStimulus(1'b0, 2'b01, rotate_value, 1'b1, 6'd3, 1'b0);
      checkOutput("rot_top", top, 32'hA);
      checkOutput("rot_second", second, 32'hD);
      checkOutput("rot_third", third, 32'hC);
      checkOutput("rot_e3", rotate_value, 32'hB);
      checkOutput("rot_depth", 32'(depth), 32'd4);
      checkOutput("rot_underflow", 32'(underflow), 32'd0);
      applyStimulus(1'b0, 2'b00, 32'h55, 1'b1, 6'd5, 1'b0);
      checkOutput("rot_deep_second", second, 32'hA);
      checkOutput("rot_deep_e4", 32'(dut.entries[4]), 32'hB);
      checkOutput("rot_deep_underflow", 32'(underflow), 32'd1);
      checkOutput("rot_deep_depth", 32'(depth), 32'd4);
      applyStimulus(1'b0, 2'b01, 32'h77, 1'b1, 6'd10, 1'b0);
      checkOutput("rot_oor_top", top, 32'h77);
      checkOutput("rot_oor_second", second, 32'hA);
      checkOutput("rot_oor_depth", 32'(depth), 32'd4);
      checkOutput("rotval_oor", rotate_value, 32'h0);
      applyStimulus(1'b0, 2'b01, 32'h88, 1'b1, 6'd0, 1'b1);
      checkOutput("rot0_top", top, 32'h88);
      checkOutput("rot0_second", second, 32'hA);
      checkOutput("rot0_clear", 32'(underflow), 32'd0);

      // Saturation and overflow
      pulse_reset();
      for (int v = 1; v <= DEPTH + 1; v++) push(WW'(v));
      checkOutput("full_depth", 32'(depth), 32'(DEPTH));
      checkOutput("full_overflow", 32'(overflow), 32'd1);
      checkOutput("full_top", top, 32'(DEPTH + 1));
      rotate_addr = 6'(DEPTH - 1);
      #1;
      checkOutput("full_bottom", rotate_value, 32'd2);
      applyStimulus(1'b0, 2'b01, 32'd10, 1'b0, 6'd0, 1'b1);
      checkOutput("set_beats_clear", 32'(overflow), 32'd1);
      checkOutput("sat_depth", 32'(depth), 32'(DEPTH));
      applyStimulus(1'b0, 2'b00, 32'd10, 1'b0, 6'd0, 1'b1);
      checkOutput("clear_overflow", 32'(overflow), 32'd0);
      push(32'd11);
      checkOutput("reoverflow", 32'(overflow), 32'd1);

      // Halt freezes state; rotate_value keeps tracking rotate_addr
      for (int k = 0; k < 3; k++) applyStimulus(1'b1, 2'b01, 32'hFF, 1'b0, 6'd0, 1'b0);
      checkOutput("halt_top", top, 32'd11);
      checkOutput("halt_second", second, 32'd10);
      checkOutput("halt_depth", 32'(depth), 32'(DEPTH));
      checkOutput("halt_overflow", 32'(overflow), 32'd1);
      rotate_addr = 6'd7;
      #1;
      checkOutput("halt_rotval7", rotate_value, 32'd4);
      rotate_addr = 6'd2;
      #1;
      checkOutput("halt_rotval2", rotate_value, 32'd9);
      applyStimulus(1'b1, 2'b01, 32'hFF, 1'b0, 6'd0, 1'b1);
      checkOutput("halt_clear", 32'(overflow), 32'd0);
      checkOutput("halt_clear_top", top, 32'd11);

      // Asynchronous reset between edges with a push presented
      halt        = 1'b0;
      clear_flags = 1'b0;
      movement    = 2'b01;
      next_top    = 32'h99;
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("async_top", top, 32'h0);
      checkOutput("async_second", second, 32'h0);
      checkOutput("async_depth", 32'(depth), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("async_held", top, 32'h0);
      reset_n = 1'b1;
      push(32'h99);
      checkOutput("post_reset_depth", 32'(depth), 32'd1);
      checkOutput("post_reset_top", top, 32'h99);

      $display("CHECKS %0d ERRORS %0d", check_count, error_count);
      $finish;
   end

endmodule

// File: doc/dstack_file.md
Name: dstack_file

Overview:
- Data-stack storage that executes the per-cycle stack commands issued by `dstack_control` (`movement`, `next_top`, `rotate`, `rotate_addr`).
- Returns `top`, `second`, `third` and `rotate_value` to the stack controller and ALU path.
- Implemented as a shift-register array; entry 0 is the top of stack.
- Tracks occupancy and raises sticky overflow/underflow flags.

Parameters:
- WORD_WIDTH, 32, width of each stack entry.
- DEPTH, 64, number of entries; legal range 4..64.
- DEPTH_BITS, $clog2(DEPTH+1), width of the occupancy counter.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- halt  input  1  freezes all state when high.
- movement  input  2  00 replace, 01 push, 10 pop1, 11 pop2.
- next_top  input  WORD_WIDTH  value written into entry 0 on every non-halted cycle.
- rotate  input  1  rotate command; takes precedence over movement.
- rotate_addr  input  6  index of the entry brought to the top by a rotate.
- clear_flags  input  1  clears the sticky flags.
- top  output  WORD_WIDTH  entry 0.
- second  output  WORD_WIDTH  entry 1.
- third  output  WORD_WIDTH  entry 2.
- rotate_value  output  WORD_WIDTH  combinational read of entry[rotate_addr]; 0 if rotate_addr >= DEPTH.
- depth  output  DEPTH_BITS  occupancy count.
- overflow  output  1  sticky; set when a push is lost off the bottom.
- underflow  output  1  sticky; set on a pop or rotate beyond the occupancy.

Behaviour:
- Reset (async, reset_n low): all entries, depth, overflow and underflow go to 0 immediately.
- Reset mid-operation: the command in flight is discarded.
- Outputs top/second/third are direct register reads with zero latency. A command seen at edge N is reflected in the outputs after edge N.
- halt=1: nothing changes, including the flags. clear_flags is still honoured.
- Command precedence when not halted: rotate, then movement.
- Rotate (rotate=1, n=rotate_addr, n<DEPTH):
  - e[0]<=next_top.
  - e[i]<=e[i-1] for 1<=i<=n.
  - e[i] unchanged for i>n.
  - depth unchanged.
  - If n>=depth, set underflow; the shift is still performed.
- Rotate with n>=DEPTH: behaves as replace; underflow set.
- Rotate with n=0: behaves as replace.
- movement 00 (replace): e[0]<=next_top; all other entries and depth unchanged.
- movement 01 (push):
  - e[0]<=next_top; e[i]<=e[i-1] for all i>=1; the old e[DEPTH-1] is discarded.
  - depth+1, saturating at DEPTH.
  - If depth==DEPTH before the push, set overflow.
- movement 10 (pop1):
  - e[0]<=next_top; e[i]<=e[i+1] for 1<=i<DEPTH-1; e[DEPTH-1]<=0.
  - depth-1, clamped at 0.
  - If depth<1 before the pop, set underflow.
- movement 11 (pop2):
  - e[0]<=next_top; e[i]<=e[i+2] for i>=1; the last two entries <=0.
  - depth-2, clamped at 0.
  - If depth<2 before the pop, set underflow.
- The replace semantics of e[0] on pops are intentional: the controller already selects second/third/ALU result as next_top.
- Flags:
  - Sticky.
  - clear_flags=1 clears both at the edge.
  - If a set condition and clear_flags occur in the same cycle, the set wins.
- depth has no effect on the data path. It only drives the flags and diagnostics.
- rotate_value is purely combinational from the current entries and rotate_addr; it is independent of halt.

Test Plan:
1. Reset, then push 0x11, 0x22, 0x33 (movement=01, next_top as listed) -> top=0x33, second=0x22, third=0x11, depth=3, flags 0.
2. From state 1, movement=10 with next_top=0x22 -> top=0x22, second=0x11, third=0, depth=2. Then movement=11 with next_top=0x5 -> top=0x5, depth=0, underflow=0. Then one more pop1 -> depth=0, underflow=1.
3. Push 0xA, 0xB, 0xC, 0xD, then rotate=1, rotate_addr=3, next_top=rotate_value -> rotate_value=0xA before the edge; after the edge top=0xA, second=0xD, third=0xC, e[3]=0xB, depth=4.
4. Push DEPTH+1 values 1..DEPTH+1 -> depth=DEPTH, overflow=1, top=DEPTH+1, e[DEPTH-1]=2. Then clear_flags=1 together with another push -> overflow remains 1. Then clear_flags alone -> overflow=0.
5. halt=1 with movement=01, next_top=0xFF for 3 cycles -> entries, depth and flags unchanged; rotate_value still tracks rotate_addr.
6. Assert reset_n=0 asynchronously between clock edges while a push is presented -> all outputs 0 before the next edge. Release reset -> the first push yields depth=1.
